regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning register and data port width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; depth is 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 0, meaning register 0 is hardwired to zero when 1.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 The block SHALL have a single clock and a synchronous, active-high reset, named CLK and RST.
REQ-006 The block SHALL have the following ports:
  CLK  in  1  clock, all state updates on rising edge
  RST  in  1  synchronous active-high reset
  rega_addr  in  ADDR_W  read port A address
  regb_addr  in  ADDR_W  read port B address
  rega_data  out  DATA_W  registered read data, port A
  regb_data  out  DATA_W  registered read data, port B
  rega_busy  out  1  registered scoreboard bit for rega_addr
  regb_busy  out  1  registered scoreboard bit for regb_addr
  write_enable  in  1  write-back strobe
  write_addr  in  ADDR_W  write-back address
  write_data  in  DATA_W  write-back data
  rsv_enable  in  1  reserve destination (set busy) strobe
  rsv_addr  in  ADDR_W  register to reserve
  busy_count  out  ADDR_W+1  number of registers currently busy

Function
REQ-007 Reads SHALL have 1-cycle latency: addresses sampled at edge N appear on rega_data/regb_data after edge N, every cycle, with no idle phase.
REQ-008 Writes SHALL take effect at the edge where write_enable=1; one write per cycle.
REQ-009 With BYPASS=1, a read at edge N of the address written at edge N SHALL return write_data; with BYPASS=0 it SHALL return the old value.
REQ-010 Both read ports SHALL operate independently; equal addresses SHALL return identical data and busy.
REQ-011 Scoreboard: one busy bit per register; rsv_enable=1 SHALL set busy[rsv_addr] at that edge.
REQ-012 write_enable=1 SHALL clear busy[write_addr] at that edge.
REQ-013 Simultaneous reserve and write-back to the same address SHALL leave busy=1 (reserve wins) and still update the data.
REQ-014 Reserving an already-busy register SHALL be legal and leave busy=1; busy_count SHALL not change.
REQ-015 Writing a non-busy register SHALL be legal; busy stays 0.
REQ-016 rega_busy/regb_busy SHALL reflect the busy bit after that edge's updates (post-update view, consistent with BYPASS=1 data).
REQ-017 busy_count SHALL equal the population count of busy bits after each edge; range 0..2**ADDR_W, no wrap.
REQ-018 busy_count SHALL change by at most +1/-1 per cycle; reserve and clear on different addresses in one cycle SHALL net 0.
REQ-019 With ZERO_REG=1: writes and reserves to address 0 SHALL be ignored; reads of address 0 SHALL return 0 with busy=0, including under bypass.
REQ-020 Out-of-range behaviour SHALL not exist: every ADDR_W address is a valid register.

Reset
REQ-021 RST=1 at an edge SHALL clear all registers, all busy bits, rega_data, regb_data, rega_busy, regb_busy and busy_count to 0.
REQ-022 RST SHALL take priority over concurrent write_enable and rsv_enable; those operations are discarded.
REQ-023 First valid read data SHALL appear one edge after the first edge with RST=0.

Verification
REQ-024 Write 0x1234 to r3, next cycle read A=r3 -> rega_data=0x1234 one cycle later.
REQ-025 Same edge: write r5=0xBEEF, read A=r5, B=r5 -> BYPASS=1: both 0xBEEF; BYPASS=0: both old value 0x0000.
REQ-026 Reserve r2, r7 on consecutive cycles -> busy_count 1 then 2; write r2 -> busy_count 1, read r2 busy=0, r7 busy=1.
REQ-027 Same edge reserve r4 and write r4=0x00AA -> busy[4]=1, data 0x00AA, busy_count +1.
REQ-028 ZERO_REG=1: write r0=0xFFFF and reserve r0 -> read r0 returns 0x0000, busy 0, busy_count unchanged.
REQ-029 Fill all 16 busy bits, assert RST with write_enable=1 to r1=0x5555 -> all outputs 0, busy_count 0, r1 reads 0x0000 after reset.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with two registered read ports, one write-back port and a per-register
// busy scoreboard with a population counter, optional write-to-read forwarding and hardwired r0.
module regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] rega_addr,
  input  logic [ADDR_W-1:0] regb_addr,
  output logic [DATA_W-1:0] rega_data,
  output logic [DATA_W-1:0] regb_data,
  output logic              rega_busy,
  output logic              regb_busy,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_enable,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W:0]   busy_count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [CNT_W-1:0]  r_busy_count;
  logic [DATA_W-1:0] r_rega_data;
  logic [DATA_W-1:0] r_regb_data;
  logic              r_rega_busy;
  logic              r_regb_busy;

  logic              w_we;
  logic              w_rsv;
  logic              w_inc;
  logic              w_dec;
  logic [DEPTH-1:0]  w_busy_next;
  logic [DATA_W-1:0] w_rega_data;
  logic [DATA_W-1:0] w_regb_data;

  // With a hardwired r0, write-backs and reserves to address 0 are dropped here.
  assign w_we  = write_enable && !((ZERO_REG != 0) && (write_addr == '0));
  assign w_rsv = rsv_enable   && !((ZERO_REG != 0) && (rsv_addr   == '0));

  // Reserve is applied after clear so a same-address reserve wins.
  always_comb begin
    w_busy_next = r_busy;
    if (w_we)  w_busy_next[write_addr] = 1'b0;
    if (w_rsv) w_busy_next[rsv_addr]   = 1'b1;
  end

  // Counter deltas: only real 0->1 / 1->0 transitions move the count.
  assign w_inc = w_rsv && !r_busy[rsv_addr];
  assign w_dec = w_we && r_busy[write_addr] && !(w_rsv && (rsv_addr == write_addr));

  always_comb begin
    w_rega_data = r_regs[rega_addr];
    w_regb_data = r_regs[regb_addr];
    if ((BYPASS != 0) && w_we && (write_addr == rega_addr)) w_rega_data = write_data;
    if ((BYPASS != 0) && w_we && (write_addr == regb_addr)) w_regb_data = write_data;
    if ((ZERO_REG != 0) && (rega_addr == '0)) w_rega_data = '0;
    if ((ZERO_REG != 0) && (regb_addr == '0)) w_regb_data = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
      r_rega_data  <= '0;
      r_regb_data  <= '0;
      r_rega_busy  <= 1'b0;
      r_regb_busy  <= 1'b0;
    end else begin
      if (w_we) r_regs[write_addr] <= write_data;
      r_busy       <= w_busy_next;
      r_busy_count <= r_busy_count + CNT_W'(w_inc) - CNT_W'(w_dec);
      r_rega_data  <= w_rega_data;
      r_regb_data  <= w_regb_data;
      r_rega_busy  <= w_busy_next[rega_addr];
      r_regb_busy  <= w_busy_next[regb_addr];
    end
  end

  assign rega_data  = r_rega_data;
  assign regb_data  = r_regb_data;
  assign rega_busy  = r_rega_busy;
  assign regb_busy  = r_regb_busy;
  assign busy_count = r_busy_count;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default instance (bypass on) and a ZERO_REG=1/BYPASS=0 instance
// share stimulus; expectations come from a table and from a behavioural scoreboard model.
module tb_regfile_sb;

  typedef struct packed {
    logic [15:0] a_data;
    logic [15:0] b_data;
    logic        a_busy;
    logic        b_busy;
    logic [4:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        rsv;
    logic [3:0]  rsv_a;
    logic [3:0]  a;
    logic [3:0]  b;
    exp_t        exp;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  rega_addr, regb_addr, write_addr, rsv_addr;
  logic        write_enable, rsv_enable;
  logic [15:0] write_data;
  logic [15:0] a_data0, b_data0, a_data1, b_data1;
  logic        a_busy0, b_busy0, a_busy1, b_busy1;
  logic [4:0]  cnt0, cnt1;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] m_regs [2][16];
  logic [15:0] m_busy [2];
  exp_t q0[$];
  exp_t q1[$];
  vec_t tbl[11];

  always #5 CLK = ~CLK;

  regfile_sb dut0 (
    .CLK(CLK), .RST(RST), .rega_addr(rega_addr), .regb_addr(regb_addr),
    .rega_data(a_data0), .regb_data(b_data0), .rega_busy(a_busy0), .regb_busy(b_busy0),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .busy_count(cnt0)
  );

  regfile_sb #(.ZERO_REG(1), .BYPASS(0)) dut1 (
    .CLK(CLK), .RST(RST), .rega_addr(rega_addr), .regb_addr(regb_addr),
    .rega_data(a_data1), .regb_data(b_data1), .rega_busy(a_busy1), .regb_busy(b_busy1),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .rsv_enable(rsv_enable), .rsv_addr(rsv_addr), .busy_count(cnt1)
  );

  function automatic vec_t mk(input logic rst, input logic we, input logic [3:0] wa,
                              input logic [15:0] wd, input logic rsv, input logic [3:0] ra,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic eab, input logic ebb, input logic [4:0] ec);
    vec_t v;
    v.rst = rst; v.we = we; v.waddr = wa; v.wdata = wd; v.rsv = rsv; v.rsv_a = ra;
    v.a = a; v.b = b;
    v.exp.a_data = ea; v.exp.b_data = eb; v.exp.a_busy = eab; v.exp.b_busy = ebb;
    v.exp.cnt = ec;
    return v;
  endfunction

  // Spec-level model: k=0 is BYPASS=1/ZERO_REG=0, k=1 is BYPASS=0/ZERO_REG=1.
  task automatic model(input int k, input vec_t v, output exp_t e);
    logic [15:0] nr [16];
    logic [15:0] nb;
    logic zr, bp, we_e, rsv_e;
    zr = (k == 1);
    bp = (k == 0);
    if (v.rst) begin
      for (int i = 0; i < 16; i++) m_regs[k][i] = 16'h0;
      m_busy[k] = 16'h0;
      e = '0;
      return;
    end
    we_e  = v.we  && !(zr && v.waddr == 4'd0);
    rsv_e = v.rsv && !(zr && v.rsv_a == 4'd0);
    for (int i = 0; i < 16; i++) nr[i] = m_regs[k][i];
    nb = m_busy[k];
    if (we_e) begin
      nr[v.waddr] = v.wdata;
      nb[v.waddr] = 1'b0;
    end
    if (rsv_e) nb[v.rsv_a] = 1'b1;
    e.a_data = bp ? nr[v.a] : m_regs[k][v.a];
    e.b_data = bp ? nr[v.b] : m_regs[k][v.b];
    e.a_busy = nb[v.a];
    e.b_busy = nb[v.b];
    e.cnt    = 5'($countones(nb));
    for (int i = 0; i < 16; i++) m_regs[k][i] = nr[i];
    m_busy[k] = nb;
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got 0x%04h expected 0x%04h", name, idx, act, exp);
  endtask

  task automatic step(input vec_t v, input bit use_tbl, input int idx);
    exp_t e0, e1, p0, p1;
    @(negedge CLK);
    RST = v.rst; write_enable = v.we; write_addr = v.waddr; write_data = v.wdata;
    rsv_enable = v.rsv; rsv_addr = v.rsv_a; rega_addr = v.a; regb_addr = v.b;
    model(0, v, e0);
    model(1, v, e1);
    q0.push_back(use_tbl ? v.exp : e0);
    q1.push_back(e1);
    @(posedge CLK);
    #1;
    p0 = q0.pop_front();
    p1 = q1.pop_front();
    check("dut0 rega_data", idx, a_data0, p0.a_data);
    check("dut0 regb_data", idx, b_data0, p0.b_data);
    check("dut0 rega_busy", idx, 16'(a_busy0), 16'(p0.a_busy));
    check("dut0 regb_busy", idx, 16'(b_busy0), 16'(p0.b_busy));
    check("dut0 busy_count", idx, 16'(cnt0), 16'(p0.cnt));
    check("dut1 rega_data", idx, a_data1, p1.a_data);
    check("dut1 regb_data", idx, b_data1, p1.b_data);
    check("dut1 rega_busy", idx, 16'(a_busy1), 16'(p1.a_busy));
    check("dut1 regb_busy", idx, 16'(b_busy1), 16'(p1.b_busy));
    check("dut1 busy_count", idx, 16'(cnt1), 16'(p1.cnt));
  endtask

  initial begin
    vec_t v;
    RST = 1'b1; write_enable = 1'b0; write_addr = 4'd0; write_data = 16'h0;
    rsv_enable = 1'b0; rsv_addr = 4'd0; rega_addr = 4'd0; regb_addr = 4'd0;
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 16'h0;
      for (int i = 0; i < 16; i++) m_regs[k][i] = 16'h0;
    end

    //           rst we wa    wdata      rsv ra    a     b     exp_a      exp_b     ab bb cnt
    tbl[0]  = mk(1, 1, 4'd1, 16'h5555, 1, 4'd1, 4'd0, 4'd0, 16'h0000, 16'h0000, 0, 0, 5'd0);
    tbl[1]  = mk(0, 1, 4'd3, 16'h1234, 0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 0, 0, 5'd0);
    tbl[2]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd3, 4'd3, 16'h1234, 16'h1234, 0, 0, 5'd0);
    tbl[3]  = mk(0, 1, 4'd5, 16'hBEEF, 0, 4'd0, 4'd5, 4'd5, 16'hBEEF, 16'hBEEF, 0, 0, 5'd0);
    tbl[4]  = mk(0, 0, 4'd0, 16'h0000, 1, 4'd2, 4'd2, 4'd7, 16'h0000, 16'h0000, 1, 0, 5'd1);
    tbl[5]  = mk(0, 0, 4'd0, 16'h0000, 1, 4'd7, 4'd2, 4'd7, 16'h0000, 16'h0000, 1, 1, 5'd2);
    tbl[6]  = mk(0, 1, 4'd2, 16'h0011, 0, 4'd0, 4'd2, 4'd7, 16'h0011, 16'h0000, 0, 1, 5'd1);
    tbl[7]  = mk(0, 1, 4'd4, 16'h00AA, 1, 4'd4, 4'd4, 4'd4, 16'h00AA, 16'h00AA, 1, 1, 5'd2);
    tbl[8]  = mk(0, 0, 4'd0, 16'h0000, 1, 4'd4, 4'd4, 4'd3, 16'h00AA, 16'h1234, 1, 0, 5'd2);
    tbl[9]  = mk(0, 1, 4'd7, 16'h7777, 1, 4'd9, 4'd9, 4'd7, 16'h0000, 16'h7777, 1, 0, 5'd2);
    tbl[10] = mk(0, 1, 4'd8, 16'h0808, 0, 4'd0, 4'd8, 4'd4, 16'h0808, 16'h00AA, 0, 1, 5'd2);

    for (int i = 0; i < 11; i++) step(tbl[i], 1'b1, i);

    // r0 write + reserve: ignored by the hardwired-zero instance, honoured by the default one.
    step(mk(0, 1, 4'd0, 16'hFFFF, 1, 4'd0, 4'd0, 4'd0, 16'h0, 16'h0, 0, 0, 5'd0), 1'b0, 100);
    step(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 4'd5, 16'h0, 16'h0, 0, 0, 5'd0), 1'b0, 101);

    // Fill every busy bit, then reset under a concurrent write and reserve.
    for (int i = 0; i < 16; i++)
      step(mk(0, 0, 4'd0, 16'h0, 1, 4'(i), 4'(i), 4'(i + 1), 16'h0, 16'h0, 0, 0, 5'd0),
           1'b0, 200 + i);
    step(mk(1, 1, 4'd1, 16'h5555, 1, 4'd6, 4'd1, 4'd6, 16'h0, 16'h0, 0, 0, 5'd0), 1'b1, 300);
    step(mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd1, 4'd6, 16'h0, 16'h0, 0, 0, 5'd0), 1'b1, 301);

    for (int i = 0; i < 300; i++) begin
      v = mk(($urandom_range(0, 31) == 0), 1'($urandom), 4'($urandom), 16'($urandom),
             1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             16'h0, 16'h0, 0, 0, 5'd0);
      if ($urandom_range(0, 3) == 0) v.rsv_a = v.waddr;
      if ($urandom_range(0, 3) == 0) v.a = v.waddr;
      if ($urandom_range(0, 3) == 0) v.b = v.a;
      step(v, 1'b0, 400 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
